// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester shared ALU: op codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_share_arb_pkg;

    // Op-code encoding presented on i_reqN_op.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Operation sequencing: accept in IDLE, compute in EXEC, hold result in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_core.sv
// Combinational ALU datapath: add / sub / multiply modulo 2^DATA_W plus overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   op     : operation code (OP_ADD, OP_SUB, OP_MUL, OP_RSV)
//   a, b   : operands
//   result : low DATA_W bits of the operation (0 for OP_RSV)
//   flag   : add carry-out, sub borrow (a < b), nonzero high product half; 0 for OP_RSV
module alu_share_core
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              flag
);

    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        // One extra bit on the sum exposes the carry; the product is computed
        // full width so the upper half can be inspected for overflow.
        sum    = {1'b0, a} + {1'b0, b};
        diff   = a - b;
        prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        result = '0;
        flag   = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                flag   = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff;
                flag   = (a < b);
            end
            OP_MUL: begin
                result = prod[DATA_W-1:0];
                flag   = |prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                // Reserved op: zero result, no flag, normal sequencing.
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation at a time.
// Latency: response valid 2 edges after acceptance; at least 3 cycles per operation.
// Backpressure: response held stable until i_rsp_ready; no request accepted until it completes.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   i_reqN_valid/op/a/b        : request from requester N (N = 0, 1)
//   o_reqN_ready               : request N accepted when valid & ready at a rising edge
//   o_rsp_valid/id/data        : response (id/data forced to 0 while not valid)
//   i_rsp_ready                : consumer accepts the response
//   o_rsp_ovf                  : overflow flag, present only with ALU_SHARE_ARB_OVF_EN defined
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req0_valid,
    input  logic [1:0]        i_req0_op,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req1_valid,
    input  logic [1:0]        i_req1_op,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    input  logic              i_rsp_ready
`ifdef ALU_SHARE_ARB_OVF_EN
    ,
    output logic              o_rsp_ovf
`endif
);

    state_t              state_q, state_d;
    logic                last_q, last_d;       // requester granted most recently
    logic                id_q, id_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef ALU_SHARE_ARB_OVF_EN
    logic                rsp_ovf_q, rsp_ovf_d;
`endif

    logic                grant_id;
    logic                accept;
    logic [DATA_W-1:0]   core_result;
`ifdef ALU_SHARE_ARB_OVF_EN
    logic                core_flag;
`else
    logic                core_flag_unused;
`endif

    // The ALU works only on the latched operands, so requesters may drop
    // their inputs as soon as they are accepted.
    alu_share_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
`ifdef ALU_SHARE_ARB_OVF_EN
        .flag   (core_flag)
`else
        .flag   (core_flag_unused)
`endif
    );

    // Round-robin: on a tie the requester not granted last wins; a lone
    // requester always wins. With neither valid the value is irrelevant.
    always_comb begin
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = i_req1_valid;
        end
    end

    // Ready is combinational on valid so an idle arbiter accepts in the same
    // cycle a request appears. Gated by reset so every output is 0 while it
    // is held, even though the state register already reads IDLE.
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        if (!reset && (state_q == ST_IDLE)) begin
            o_req0_ready = i_req0_valid && (grant_id == 1'b0);
            o_req1_ready = i_req1_valid && (grant_id == 1'b1);
        end
    end

    assign accept = o_req0_ready || o_req1_ready;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_SHARE_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = grant_id;
                    last_d  = grant_id;
                    op_d    = grant_id ? i_req1_op : i_req0_op;
                    a_d     = grant_id ? i_req1_a  : i_req0_a;
                    b_d     = grant_id ? i_req1_b  : i_req0_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Register the ALU output; it is then held unchanged in RESP.
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = core_result;
`ifdef ALU_SHARE_ARB_OVF_EN
                rsp_ovf_d   = core_flag;
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Readys stay low here, so the completing cycle never overlaps
                // a new acceptance.
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = 1'b0;
                    rsp_data_d  = '0;
`ifdef ALU_SHARE_ARB_OVF_EN
                    rsp_ovf_d   = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first tie; an in-flight
    // operation is simply dropped by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_SHARE_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_SHARE_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
`ifdef ALU_SHARE_ARB_OVF_EN
    assign o_rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios with literal expectations plus a
// per-cycle comparison against a transaction-level model (expected-response queue).
// Overflow is compared only when ALU_SHARE_ARB_OVF_EN is defined.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req0_valid, i_req1_valid;
    logic [1:0]    i_req0_op, i_req1_op;
    logic [W-1:0]  i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic          o_req0_ready, o_req1_ready;
    logic          o_rsp_valid, o_rsp_id;
    logic [W-1:0]  o_rsp_data;
    logic          i_rsp_ready;
    logic          ovf_obs;

`ifdef ALU_SHARE_ARB_OVF_EN
    logic          o_rsp_ovf;
    assign ovf_obs = o_rsp_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req0_valid (i_req0_valid),
        .i_req0_op    (i_req0_op),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .i_req1_valid (i_req1_valid),
        .i_req1_op    (i_req1_op),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .o_req0_ready (o_req0_ready),
        .o_req1_ready (o_req1_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_data   (o_rsp_data),
        .i_rsp_ready  (i_rsp_ready)
`ifdef ALU_SHARE_ARB_OVF_EN
        ,
        .o_rsp_ovf    (o_rsp_ovf)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic          id;
        logic [W-1:0]  data;
        logic          ovf;
    } rsp_t;

    // Plain integer arithmetic: the true result, then reduced modulo 2^W.
    function automatic rsp_t model(input logic id, input logic [1:0] op, input int a, input int b);
        rsp_t r;
        int full;
        int m;
        int red;
        m = 1 << W;
        case (op)
            2'b00:   full = a + b;
            2'b01:   full = a - b;
            2'b10:   full = a * b;
            default: full = 0;
        endcase
        red    = ((full % m) + m) % m;
        r.id   = id;
        r.data = red[W-1:0];
        r.ovf  = (full >= m) || (full < 0);
        return r;
    endfunction

    rsp_t exp_q[$];
    logic last_m;
    bit   busy;
    int   age;

    // One compare process: every negedge, outputs vs. model, then the model
    // advances for the coming rising edge (inputs are stable across it).
    always @(negedge clk) begin
        logic er0, er1, erv;
        if (reset) begin
            check("rst_req0_ready", o_req0_ready, 0);
            check("rst_req1_ready", o_req1_ready, 0);
            check("rst_rsp_valid",  o_rsp_valid,  0);
            check("rst_rsp_id",     o_rsp_id,     0);
            check("rst_rsp_data",   o_rsp_data,   0);
            exp_q.delete();
            busy   = 0;
            age    = 0;
            last_m = 1'b1;
        end else begin
            if (busy) age++;
            er0 = !busy && i_req0_valid && (!i_req1_valid || last_m);
            er1 = !busy && i_req1_valid && (!i_req0_valid || !last_m);
            erv = busy && (age >= 2);
            check("mdl_req0_ready", o_req0_ready, er0);
            check("mdl_req1_ready", o_req1_ready, er1);
            check("mdl_rsp_valid",  o_rsp_valid,  erv);
            if (erv && exp_q.size() > 0) begin
                check("mdl_rsp_id",   o_rsp_id,   exp_q[0].id);
                check("mdl_rsp_data", o_rsp_data, exp_q[0].data);
`ifdef ALU_SHARE_ARB_OVF_EN
                check("mdl_rsp_ovf",  ovf_obs,    exp_q[0].ovf);
`endif
            end else begin
                check("mdl_idle_id",   o_rsp_id,   0);
                check("mdl_idle_data", o_rsp_data, 0);
            end
            if (erv && i_rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                busy = 0;
            end else if (er0) begin
                exp_q.push_back(model(1'b0, i_req0_op, int'(i_req0_a), int'(i_req0_b)));
                last_m = 1'b0;
                busy   = 1;
                age    = 0;
            end else if (er1) begin
                exp_q.push_back(model(1'b1, i_req1_op, int'(i_req1_a), int'(i_req1_b)));
                last_m = 1'b1;
                busy   = 1;
                age    = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            i_req0_valid = 1'b1; i_req0_op = op; i_req0_a = a; i_req0_b = b;
        end else begin
            i_req1_valid = 1'b1; i_req1_op = op; i_req1_a = a; i_req1_b = b;
        end
    endtask

    // Waits for a grant, lets the accepting edge pass, then drops that valid.
    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_req0_ready || o_req1_ready) begin
                who = o_req1_ready ? 1 : 0;
                break;
            end
        end
        if (who < 0) check("grant_timeout", 0, 1);
        tick();
        if (who == 0) i_req0_valid = 1'b0;
        else if (who == 1) i_req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic id, output logic [W-1:0] data, output logic ovf);
        bit got;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) check("rsp_timeout", 0, 1);
        id   = o_rsp_id;
        data = o_rsp_data;
        ovf  = ovf_obs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int           who;
        logic         rid;
        logic [W-1:0] rdata;
        logic         rovf;

        reset = 1'b1;
        i_req0_valid = 1'b0; i_req0_op = OP_ADD; i_req0_a = '0; i_req0_b = '0;
        i_req1_valid = 1'b0; i_req1_op = OP_ADD; i_req1_a = '0; i_req1_b = '0;
        i_rsp_ready = 1'b1;
        set_req(0, OP_ADD, 8'd10, 8'd2);

        // Reset holds readys low even with a valid request.
        @(negedge clk);
        check("reset_ready0", o_req0_ready, 0);
        check("reset_rsp_valid", o_rsp_valid, 0);

        // Lone add: ready in IDLE, response 2 edges after acceptance.
        tick(); reset = 1'b0;
        @(negedge clk);
        check("lone_ready0", o_req0_ready, 1);
        tick(); i_req0_valid = 1'b0;
        @(negedge clk);
        check("lone_exec_no_rsp", o_rsp_valid, 0);
        @(negedge clk);
        check("lone_rsp_valid", o_rsp_valid, 1);
        check("lone_rsp_id", o_rsp_id, 0);
        check("lone_rsp_data", o_rsp_data, 12);

        // Simultaneous requests straight after reset.
        tick(); reset = 1'b1;
        set_req(0, OP_SUB, 8'd10, 8'd2);
        set_req(1, OP_MUL, 8'd10, 8'd2);
        tick(); reset = 1'b0;
        wait_grant(who);            check("tie1_winner", who, 0);
        wait_rsp(rid, rdata, rovf); check("tie1_id", rid, 0); check("tie1_data", rdata, 8);
        wait_grant(who);            check("tie1_second", who, 1);
        wait_rsp(rid, rdata, rovf); check("tie2_id", rid, 1); check("tie2_data", rdata, 20);

        // Re-issue both: pointer now favours requester 0 again.
        tick();
        set_req(0, OP_ADD, 8'd3, 8'd4);
        set_req(1, OP_ADD, 8'd5, 8'd6);
        wait_grant(who);            check("reissue_winner", who, 0);
        wait_rsp(rid, rdata, rovf); check("reissue_data0", rdata, 7);
        wait_grant(who);            check("reissue_second", who, 1);
        wait_rsp(rid, rdata, rovf); check("reissue_data1", rdata, 11);

        // Wrap and overflow.
        tick(); set_req(1, OP_MUL, 8'd20, 8'd20);
        wait_grant(who);
        wait_rsp(rid, rdata, rovf); check("mul_wrap_data", rdata, 144);
`ifdef ALU_SHARE_ARB_OVF_EN
        check("mul_ovf", rovf, 1);
`endif
        tick(); set_req(0, OP_SUB, 8'd2, 8'd10);
        wait_grant(who);
        wait_rsp(rid, rdata, rovf); check("sub_wrap_data", rdata, 248);
`ifdef ALU_SHARE_ARB_OVF_EN
        check("sub_borrow", rovf, 1);
`endif
        tick(); set_req(1, OP_ADD, 8'd200, 8'd100);
        wait_grant(who);
        wait_rsp(rid, rdata, rovf); check("add_wrap_data", rdata, 44);
`ifdef ALU_SHARE_ARB_OVF_EN
        check("add_carry", rovf, 1);
`endif
        tick(); set_req(0, OP_RSV, 8'd7, 8'd9);
        wait_grant(who);
        wait_rsp(rid, rdata, rovf); check("rsv_data", rdata, 0);
`ifdef ALU_SHARE_ARB_OVF_EN
        check("rsv_ovf", rovf, 0);
`endif

        // Backpressure: response held for 5 cycles with another request pending.
        tick(); i_rsp_ready = 1'b0;
        set_req(0, OP_ADD, 8'd1, 8'd2);
        wait_grant(who);
        set_req(1, OP_MUL, 8'd3, 8'd3);
        wait_rsp(rid, rdata, rovf); check("bp_data", rdata, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", o_rsp_valid, 1);
            check("bp_hold_data", o_rsp_data, 3);
            check("bp_hold_ready1", o_req1_ready, 0);
        end
        tick(); i_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_complete_valid", o_rsp_valid, 1);
        check("bp_no_accept", o_req1_ready, 0);
        tick();
        @(negedge clk);
        check("bp_done_valid", o_rsp_valid, 0);
        check("bp_next_ready1", o_req1_ready, 1);
        tick(); i_req1_valid = 1'b0;
        wait_rsp(rid, rdata, rovf); check("bp_next_id", rid, 1); check("bp_next_data", rdata, 9);

        // Reset while in RESP with requester 1 waiting.
        tick(); i_rsp_ready = 1'b0;
        set_req(0, OP_ADD, 8'd5, 8'd5);
        wait_grant(who);            check("pre_rst_winner", who, 0);
        set_req(1, OP_SUB, 8'd9, 8'd4);
        wait_rsp(rid, rdata, rovf); check("pre_rst_data", rdata, 10);
        tick(); reset = 1'b1;
        #1;
        check("rst_imm_valid", o_rsp_valid, 0);
        check("rst_imm_data", o_rsp_data, 0);
        check("rst_imm_ready1", o_req1_ready, 0);
        tick(); i_rsp_ready = 1'b1;
        set_req(0, OP_ADD, 8'd1, 8'd1);
        tick(); reset = 1'b0;
        wait_grant(who);            check("post_rst_winner", who, 0);
        wait_rsp(rid, rdata, rovf); check("post_rst_id", rid, 0); check("post_rst_data", rdata, 2);
        wait_grant(who);            check("post_rst_second", who, 1);
        wait_rsp(rid, rdata, rovf); check("post_rst_data1", rdata, 5);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter DATA_W, default 8, operand and result width.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Ports i_req0_valid / i_req1_valid  input  1 each  request pending from requester 0 / 1.
REQ-005 Ports i_req0_op / i_req1_op  input  2 each  op code: 00 add, 01 sub, 10 multiply, 11 reserved.
REQ-006 Ports i_req0_a, i_req0_b, i_req1_a, i_req1_b  input  DATA_W each  operands.
REQ-007 Ports o_req0_ready / o_req1_ready  output  1 each  request accepted when valid and ready are both high at a rising edge.
REQ-008 Port o_rsp_valid  output  1  response available.
REQ-009 Port o_rsp_id  output  1  index of the requester that owns the response.
REQ-010 Port o_rsp_data  output  DATA_W  result.
REQ-011 Port i_rsp_ready  input  1  consumer accepts the response.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-013 In IDLE, at most one o_reqN_ready SHALL be high: the granted requester's ready equals its valid; both readys are 0 in EXEC and RESP.
REQ-014 Arbitration SHALL be round-robin: a lone valid requester wins; when both are valid, the requester not granted last wins.
REQ-015 On an accepting edge, the FSM SHALL latch op, a, b and the requester id, and go IDLE -> EXEC.
REQ-016 EXEC SHALL last exactly one cycle: the result is registered and the FSM goes to RESP, so o_rsp_valid rises on the second edge after acceptance.
REQ-017 In RESP, o_rsp_valid, o_rsp_id and o_rsp_data SHALL stay stable until a rising edge with i_rsp_ready=1, then the FSM returns to IDLE.
REQ-018 No request SHALL be accepted in the cycle the response completes, giving a minimum of 3 cycles per operation.
REQ-019 Add, sub and multiply SHALL be modulo 2^DATA_W, keeping the low DATA_W bits; sub is a minus b in two's complement.
REQ-020 Op 11 SHALL produce o_rsp_data = 0 with normal sequencing.
REQ-021 o_rsp_data and o_rsp_id SHALL be 0 whenever o_rsp_valid is 0.
REQ-022 A requester SHALL hold op and operands stable while valid is high and ready is low; the block does not check this.

Reset
REQ-023 While reset is high, state SHALL be IDLE, every output 0 and the last-granted pointer 1, so requester 0 wins the first tie.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-025 With ALU_SHARE_ARB_OVF_EN defined, an output o_rsp_ovf (1 bit, with the same validity as o_rsp_data) SHALL exist, set as follows:
- add: carry out
- sub: borrow (a < b)
- multiply: any nonzero product bit above DATA_W-1
- op 11: 0
REQ-026 Without ALU_SHARE_ARB_OVF_EN, the o_rsp_ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package alu_share_arb_pkg SHALL hold the op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_RSV) and the FSM state typedef.
REQ-028 A combinational sub-module alu_share_core SHALL compute the add/sub/multiply result and the carry/borrow/product-overflow flag from op, a and b; alu_share_arb instantiates it once.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Lone add: req0 op 00, a=10, b=2 -> o_req0_ready=1 in IDLE; o_rsp_valid rises 2 edges later with id 0, data 12.
- Simultaneous requests after reset: req0 sub 10-2, req1 mul 10*2 -> response id0 data 8, then id1 data 20.
  - Re-issue both -> id0 wins again, because the pointer alternates.
- Wrap and overflow: mul 20*20 -> data 144, ovf 1.
  - sub 2-10 -> data 248, ovf 1.
  - add 200+100 -> data 44, ovf 1 (ovf checked only with the macro defined).
- Backpressure: i_rsp_ready low for 5 cycles in RESP -> response stable throughout, both readys 0.
  - Completes on the first edge with i_rsp_ready=1; no acceptance in that cycle.
- Reset while in RESP, with req1 valid -> all outputs 0 immediately; no response issued.
  - After release, req0 and req1 both valid -> req0 granted first.
